// File: rtl/decode_stage.sv
// Decode stage: MIPS-style control decode, operand bypass, branch/jump resolution
// and a 2-entry skid buffer toward execute. Optional build macro: DECODE_BRANCH_EXT_EN.

module decode_ctrl (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       mem_write,
  output logic       alu_src,
  output logic       reg_dst,
  output logic       bit_shift,
  output logic       jump_link,
  output logic [2:0] alu_ctrl
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU codes: 000 and, 001 or, 010 add, 011 sll, 100 srl, 110 sub, 111 slt
  always_comb begin
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    bit_shift  = 1'b0;
    jump_link  = 1'b0;
    alu_ctrl   = 3'b010;
    case (opcode)
      OP_RTYPE: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        case (funct)
          FN_ADD: alu_ctrl = 3'b010;
          FN_SUB: alu_ctrl = 3'b110;
          FN_AND: alu_ctrl = 3'b000;
          FN_OR:  alu_ctrl = 3'b001;
          FN_SLT: alu_ctrl = 3'b111;
          FN_SLL: begin
            bit_shift = 1'b1;
            alu_ctrl  = 3'b011;
          end
          FN_SRL: begin
            bit_shift = 1'b1;
            alu_ctrl  = 3'b100;
          end
          FN_JR: begin
            reg_write = 1'b0;
            reg_dst   = 1'b0;
          end
          default: ;
        endcase
      end
      OP_LW: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        alu_src    = 1'b1;
      end
      OP_SW: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
      end
      OP_BEQ, OP_BNE: alu_ctrl = 3'b110;
      OP_ADDI: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
      end
      OP_ANDI: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_ctrl  = 3'b000;
      end
      OP_ORI: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_ctrl  = 3'b001;
      end
      OP_SLTI: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_ctrl  = 3'b111;
      end
      OP_JAL: begin
        reg_write = 1'b1;
        jump_link = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// state    | meaning
// ST_EMPTY | no entries, out_valid low
// ST_ONE   | slot0 holds the only entry
// ST_FULL  | slot0 oldest, slot1 newest, in_ready low
module decode_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_pc4,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  input  logic              fwd_a_en,
  input  logic              fwd_b_en,
  input  logic [DATA_W-1:0] fwd_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_ctrl,
  output logic [RA_W-1:0]   out_rs,
  output logic [RA_W-1:0]   out_rt,
  output logic [RA_W-1:0]   out_rd,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_shamt,
  output logic [DATA_W-1:0] out_rd1,
  output logic [DATA_W-1:0] out_rd2,
  output logic [DATA_W-1:0] out_pc4,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc
);

  typedef struct packed {
    logic [15:0]       ctrl;
    logic [RA_W-1:0]   rs;
    logic [RA_W-1:0]   rt;
    logic [RA_W-1:0]   rd;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] shamt;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] pc4;
  } entry_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

  state_t state, state_nxt;
  entry_t slot0, slot1, dec;

  logic [5:0]        opcode;
  logic              reg_write, mem_to_reg, mem_write, alu_src, reg_dst, bit_shift, jump_link;
  logic [2:0]        alu_ctrl;
  logic [DATA_W-1:0] op_a, op_b, imm_sext, imm_zext, br_target, j_target, target;
  logic              taken, accept, pop;

  assign opcode = in_instr[31:26];

  decode_ctrl u_ctrl (
    .opcode     (opcode),
    .funct      (in_instr[5:0]),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .mem_write  (mem_write),
    .alu_src    (alu_src),
    .reg_dst    (reg_dst),
    .bit_shift  (bit_shift),
    .jump_link  (jump_link),
    .alu_ctrl   (alu_ctrl)
  );

  assign op_a     = fwd_a_en ? fwd_data : rf_rd1;
  assign op_b     = fwd_b_en ? fwd_data : rf_rd2;
  assign imm_sext = {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]};
  assign imm_zext = {{(DATA_W-16){1'b0}}, in_instr[15:0]};

  always_comb begin
    dec       = '0;
    dec.ctrl  = {reg_write, mem_to_reg, mem_write, alu_src, reg_dst, bit_shift, jump_link,
                 alu_ctrl, 6'b0};
    dec.rs    = RA_W'(in_instr[25:21]);
    dec.rt    = RA_W'(in_instr[20:16]);
    dec.rd    = RA_W'(in_instr[15:11]);
    // logical immediates (and/or) are zero-extended, everything else sign-extended
    dec.imm   = (alu_ctrl[2:1] == 2'b00) ? imm_zext : imm_sext;
    dec.shamt = {{(DATA_W-5){1'b0}}, in_instr[10:6]};
    dec.rd1   = op_a;
    dec.rd2   = op_b;
    dec.pc4   = in_pc4;
  end

  assign br_target = in_pc4 + (imm_sext << 2);
  assign j_target  = {in_pc4[DATA_W-1:28], in_instr[25:0], 2'b00};

  always_comb begin
    taken  = 1'b0;
    target = br_target;
    case (opcode)
      6'h04: taken = (op_a == op_b);
      6'h05: taken = (op_a != op_b);
      6'h02, 6'h03: begin
        taken  = 1'b1;
        target = j_target;
      end
      6'h00: begin
        if (in_instr[5:0] == 6'h08) begin
          taken  = 1'b1;
          target = op_a;
        end
      end
`ifdef DECODE_BRANCH_EXT_EN
      6'h01: begin
        if (in_instr[20:16] == 5'h00) taken = op_a[DATA_W-1];
        else if (in_instr[20:16] == 5'h01) taken = ~op_a[DATA_W-1];
      end
      6'h06: taken = op_a[DATA_W-1] | (op_a == '0);
      6'h07: taken = ~op_a[DATA_W-1] & (op_a != '0);
`endif
      default: ;
    endcase
  end

  assign accept = in_valid & in_ready & ~flush;
  assign pop    = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state_nxt = ST_ONE;
        ST_ONE: begin
          if (accept && !pop)      state_nxt = ST_FULL;
          else if (pop && !accept) state_nxt = ST_EMPTY;
        end
        ST_FULL: if (pop) state_nxt = ST_ONE;
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state != ST_EMPTY);
    in_ready  = (state != ST_FULL);
  end

  // slot0 is always the oldest entry; a pop from FULL shifts slot1 forward
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
    end else if (!flush) begin
      case (state)
        ST_EMPTY: if (accept) slot0 <= dec;
        ST_ONE: begin
          if (accept && pop) slot0 <= dec;
          else if (accept)   slot1 <= dec;
        end
        ST_FULL: if (pop) slot0 <= slot1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= accept & taken;
      if (accept && taken) redirect_pc <= target;
    end
  end

  assign out_ctrl  = slot0.ctrl;
  assign out_rs    = slot0.rs;
  assign out_rt    = slot0.rt;
  assign out_rd    = slot0.rd;
  assign out_imm   = slot0.imm;
  assign out_shamt = slot0.shamt;
  assign out_rd1   = slot0.rd1;
  assign out_rd2   = slot0.rd2;
  assign out_pc4   = slot0.pc4;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode fields, bypass, redirects, skid buffer,
// flush and reset. Extended-branch expectations follow DECODE_BRANCH_EXT_EN.

module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, fwd_a_en, fwd_b_en, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc4, rf_rd1, rf_rd2, fwd_data;
  logic [15:0] out_ctrl;
  logic [4:0]  out_rs, out_rt, out_rd;
  logic [31:0] out_imm, out_shamt, out_rd1, out_rd2, out_pc4;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage #(.DATA_W(32), .RA_W(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .in_pc4         (in_pc4),
    .rf_rd1         (rf_rd1),
    .rf_rd2         (rf_rd2),
    .fwd_a_en       (fwd_a_en),
    .fwd_b_en       (fwd_b_en),
    .fwd_data       (fwd_data),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_ctrl       (out_ctrl),
    .out_rs         (out_rs),
    .out_rt         (out_rt),
    .out_rd         (out_rd),
    .out_imm        (out_imm),
    .out_shamt      (out_shamt),
    .out_rd1        (out_rd1),
    .out_rd2        (out_rd2),
    .out_pc4        (out_pc4),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present one instruction for exactly one rising edge
  task automatic send(input logic [31:0] ins, input logic [31:0] pc4,
                      input logic [31:0] a, input logic [31:0] b);
    in_instr = ins;
    in_pc4   = pc4;
    rf_rd1   = a;
    rf_rd2   = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc4 = '0; rf_rd1 = '0; rf_rd2 = '0;
    fwd_a_en = 1'b0; fwd_b_en = 1'b0; fwd_data = '0; flush = 1'b0; out_ready = 1'b1;
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_redir_valid", 32'(redirect_valid), 32'd0);
    check("rst_redir_pc", redirect_pc, 32'h0);
    check("rst_out_pc4", out_pc4, 32'h0);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // beq taken: 0x104 + (3 << 2)
    send(32'h10220003, 32'h104, 32'd5, 32'd5);
    check("beq_redir_valid", 32'(redirect_valid), 32'd1);
    check("beq_redir_pc", redirect_pc, 32'h110);
    check("beq_out_valid", 32'(out_valid), 32'd1);
    check("beq_ctrl", 32'(out_ctrl), 32'h0180);
    check("beq_rs", 32'(out_rs), 32'd1);
    check("beq_rt", 32'(out_rt), 32'd2);
    check("beq_imm", out_imm, 32'h3);
    step();
    check("redir_one_cycle", 32'(redirect_valid), 32'd0);
    check("beq_popped", 32'(out_valid), 32'd0);

    // bne with rt bypassed to equal rs: not taken
    fwd_b_en = 1'b1; fwd_data = 32'd5;
    send(32'h14220004, 32'h200, 32'd5, 32'd0);
    fwd_b_en = 1'b0;
    check("bne_fwd_no_redir", 32'(redirect_valid), 32'd0);
    check("bne_fwd_rd2", out_rd2, 32'd5);
    step();

    send(32'h1022FFFF, 32'h104, 32'd7, 32'd7);
    check("beq_back_valid", 32'(redirect_valid), 32'd1);
    check("beq_back_pc", redirect_pc, 32'h100);
    step();

    send(32'h10220003, 32'h104, 32'd5, 32'd6);
    check("beq_nt_no_redir", 32'(redirect_valid), 32'd0);
    step();

    // ori then addi on consecutive edges: accept and pop together
    send(32'h3403FFFF, 32'h500, 32'd0, 32'd0);
    check("ori_imm", out_imm, 32'h0000FFFF);
    check("ori_ctrl", 32'(out_ctrl), 32'h9040);
    send(32'h2003FFFF, 32'h504, 32'd0, 32'd0);
    check("addi_imm", out_imm, 32'hFFFFFFFF);
    check("addi_ctrl", 32'(out_ctrl), 32'h9080);
    check("addi_pc4", out_pc4, 32'h504);
    step();
    check("addi_popped", 32'(out_valid), 32'd0);

    send(32'h00011140, 32'h300, 32'd0, 32'd0);
    check("sll_shamt", out_shamt, 32'd5);
    check("sll_ctrl", 32'(out_ctrl), 32'h8CC0);
    check("sll_rd", 32'(out_rd), 32'd2);
    step();

    send(32'h08000040, 32'h30000010, 32'd0, 32'd0);
    check("j_redir_valid", 32'(redirect_valid), 32'd1);
    check("j_redir_pc", redirect_pc, 32'h30000100);
    step();
    send(32'h0C000040, 32'h30000010, 32'd0, 32'd0);
    check("jal_ctrl", 32'(out_ctrl), 32'h8280);
    check("jal_redir_pc", redirect_pc, 32'h30000100);
    step();
    fwd_a_en = 1'b1; fwd_data = 32'h1234;
    send(32'h00800008, 32'h400, 32'h99, 32'd0);
    fwd_a_en = 1'b0;
    check("jr_redir_valid", 32'(redirect_valid), 32'd1);
    check("jr_redir_pc", redirect_pc, 32'h1234);
    step();

    send(32'h04200005, 32'h100, 32'h80000000, 32'd0);
`ifdef DECODE_BRANCH_EXT_EN
    check("bltz_redir_valid", 32'(redirect_valid), 32'd1);
    check("bltz_redir_pc", redirect_pc, 32'h114);
`else
    check("bltz_no_redir", 32'(redirect_valid), 32'd0);
`endif
    step();

    // backpressure: three offered, two held, order preserved
    out_ready = 1'b0;
    send(32'h00221820, 32'h600, 32'h11, 32'd0);
    check("bp1_in_ready", 32'(in_ready), 32'd1);
    check("bp1_ctrl", 32'(out_ctrl), 32'h8880);
    send(32'h00221820, 32'h604, 32'h22, 32'd0);
    check("bp2_in_ready", 32'(in_ready), 32'd0);
    check("bp2_head_pc4", out_pc4, 32'h600);
    send(32'h00221820, 32'h608, 32'h33, 32'd0);
    check("bp3_in_ready", 32'(in_ready), 32'd0);
    check("bp3_stable_pc4", out_pc4, 32'h600);
    check("bp3_stable_rd1", out_rd1, 32'h11);
    out_ready = 1'b1;
    step();
    check("bp_second_valid", 32'(out_valid), 32'd1);
    check("bp_second_pc4", out_pc4, 32'h604);
    check("bp_second_rd1", out_rd1, 32'h22);
    step();
    check("bp_drained", 32'(out_valid), 32'd0);

    // flush while FULL with an incoming jump
    out_ready = 1'b0;
    send(32'h00221820, 32'h700, 32'd0, 32'd0);
    send(32'h00221820, 32'h704, 32'd0, 32'd0);
    flush = 1'b1;
    send(32'h08000040, 32'h30000010, 32'd0, 32'd0);
    flush = 1'b0;
    check("flush_full_valid", 32'(out_valid), 32'd0);
    check("flush_full_redir", 32'(redirect_valid), 32'd0);
    check("flush_full_ready", 32'(in_ready), 32'd1);

    flush = 1'b1;
    send(32'h08000040, 32'h30000010, 32'd0, 32'd0);
    flush = 1'b0;
    check("flush_accept_valid", 32'(out_valid), 32'd0);
    check("flush_accept_redir", 32'(redirect_valid), 32'd0);

    out_ready = 1'b1;
    send(32'h00221820, 32'h800, 32'd0, 32'd0);
    flush = 1'b1;
    send(32'h08000040, 32'h30000010, 32'd0, 32'd0);
    flush = 1'b0;
    check("flush_pop_valid", 32'(out_valid), 32'd0);
    check("flush_pop_redir", 32'(redirect_valid), 32'd0);

    // reset with two entries buffered
    out_ready = 1'b0;
    send(32'h00221820, 32'h900, 32'd0, 32'd0);
    send(32'h00221820, 32'h904, 32'd0, 32'd0);
    rst_n = 1'b0;
    step();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_pc4", out_pc4, 32'h0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("midrst_stays_empty", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
